// File: rtl/regfile_dual_pkg.sv
// Shared constants and helpers for the dual-write, quad-read register file.
// Write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_dual_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW       = 5;

  localparam logic [AW-1:0] ZERO_REG = '0;

  function automatic logic addr_ok(
    input logic [AW-1:0] a,
    input int unsigned   nreg
  );
    return 32'(a) < nreg;
  endfunction

  function automatic logic wr_ok(
    input logic          we,
    input logic [AW-1:0] a,
    input int unsigned   nreg
  );
    return we && (a != ZERO_REG) && addr_ok(a, nreg);
  endfunction

endpackage

// File: rtl/regfile_dual_rport.sv
// One read port: x0 / out-of-range masking, reset gating and,
// with REGFILE_BYPASS_EN, write-through forwarding (lane 2 wins).
module regfile_rport
  import regfile_dual_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic            rst,
  input  logic [AW-1:0]   raddr,
  input  logic [XLEN-1:0] regs [NREG],
`ifdef REGFILE_BYPASS_EN
  input  logic            we1,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata1,
  input  logic            we2,
  input  logic [AW-1:0]   waddr2,
  input  logic [XLEN-1:0] wdata2,
`endif
  output logic [XLEN-1:0] rdata
);

  logic rd_en;

  always_comb begin
    rd_en = !rst && (raddr != ZERO_REG) && addr_ok(raddr, NREG);
    rdata = '0;
    if (rd_en) begin
      rdata = regs[raddr];
`ifdef REGFILE_BYPASS_EN
      if (we1 && waddr1 == raddr) begin
        rdata = wdata1;
      end
      if (we2 && waddr2 == raddr) begin
        rdata = wdata2;
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_dual.sv
// Dual-write, quad-read integer register file; x0 reads as zero.
// Optional write-through forwarding: define REGFILE_BYPASS_EN.
module regfile_dual
  import regfile_dual_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we1,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata1,
  input  logic            we2,
  input  logic [AW-1:0]   waddr2,
  input  logic [XLEN-1:0] wdata2,
  input  logic [AW-1:0]   raddr1a,
  input  logic [AW-1:0]   raddr1b,
  input  logic [AW-1:0]   raddr2a,
  input  logic [AW-1:0]   raddr2b,
  output logic [XLEN-1:0] rdata1a,
  output logic [XLEN-1:0] rdata1b,
  output logic [XLEN-1:0] rdata2a,
  output logic [XLEN-1:0] rdata2b,
  output logic            wconflict
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            wconflict_q;
  logic            wconflict_d;
  logic            ok1;
  logic            ok2;

  always_comb begin
    ok1    = wr_ok(we1, waddr1, NREG);
    ok2    = wr_ok(we2, waddr2, NREG);
    regs_d = regs_q;
    if (ok1) begin
      regs_d[waddr1] = wdata1;
    end
    // Lane 2 is the younger instruction, so it lands last.
    if (ok2) begin
      regs_d[waddr2] = wdata2;
    end
    wconflict_d = wconflict_q
                | (ok1 && ok2 && waddr1 == waddr2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q      <= '{default: '0};
      wconflict_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      wconflict_q <= wconflict_d;
    end
  end

  assign wconflict = wconflict_q;

  logic [AW-1:0]   ra [4];
  logic [XLEN-1:0] rd [4];

  assign ra[0] = raddr1a;
  assign ra[1] = raddr1b;
  assign ra[2] = raddr2a;
  assign ra[3] = raddr2b;

  for (genvar g = 0; g < 4; g++) begin : g_rport
    regfile_rport #(
      .XLEN (XLEN),
      .NREG (NREG)
    ) u_rport (
      .rst    (rst),
      .raddr  (ra[g]),
      .regs   (regs_q),
`ifdef REGFILE_BYPASS_EN
      .we1    (ok1),
      .waddr1 (waddr1),
      .wdata1 (wdata1),
      .we2    (ok2),
      .waddr2 (waddr2),
      .wdata2 (wdata2),
`endif
      .rdata  (rd[g])
    );
  end

  assign rdata1a = rd[0];
  assign rdata1b = rd[1];
  assign rdata2a = rd[2];
  assign rdata2b = rd[3];

endmodule

// File: tb/tb_regfile_dual.sv
// Directed bench for regfile_dual: table of write/read vectors
// plus hand sequences for reset, same-cycle reads and async reset.
module tb_regfile_dual;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we1 = 1'b0;
  logic [4:0]  waddr1 = '0;
  logic [31:0] wdata1 = '0;
  logic        we2 = 1'b0;
  logic [4:0]  waddr2 = '0;
  logic [31:0] wdata2 = '0;
  logic [4:0]  raddr1a = '0;
  logic [4:0]  raddr1b = '0;
  logic [4:0]  raddr2a = '0;
  logic [4:0]  raddr2b = '0;
  logic [31:0] rdata1a;
  logic [31:0] rdata1b;
  logic [31:0] rdata2a;
  logic [31:0] rdata2b;
  logic        wconflict;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_dual dut (
    .clk       (clk),
    .rst       (rst),
    .we1       (we1),
    .waddr1    (waddr1),
    .wdata1    (wdata1),
    .we2       (we2),
    .waddr2    (waddr2),
    .wdata2    (wdata2),
    .raddr1a   (raddr1a),
    .raddr1b   (raddr1b),
    .raddr2a   (raddr2a),
    .raddr2b   (raddr2b),
    .rdata1a   (rdata1a),
    .rdata1b   (rdata1b),
    .rdata2a   (rdata2a),
    .rdata2b   (rdata2b),
    .wconflict (wconflict)
  );

  typedef struct {
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        we2;
    logic [4:0]  wa2;
    logic [31:0] wd2;
    logic [4:0]  ra [4];
    logic [31:0] ex [4];
    logic        wc;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(
    input logic e1, input logic [4:0] a1, input logic [31:0] d1,
    input logic e2, input logic [4:0] a2, input logic [31:0] d2,
    input logic [4:0] r0, input logic [4:0] r1,
    input logic [4:0] r2, input logic [4:0] r3,
    input logic [31:0] x0, input logic [31:0] x1,
    input logic [31:0] x2, input logic [31:0] x3,
    input logic c
  );
    vec_t v;
    v.we1 = e1; v.wa1 = a1; v.wd1 = d1;
    v.we2 = e2; v.wa2 = a2; v.wd2 = d2;
    v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2; v.ra[3] = r3;
    v.ex[0] = x0; v.ex[1] = x1; v.ex[2] = x2; v.ex[3] = x3;
    v.wc = c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_ra(input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [4:0] d);
    raddr1a = a; raddr1b = b; raddr2a = c; raddr2b = d;
  endtask

  task automatic chk_rd(input string nm, input logic [31:0] e0,
                        input logic [31:0] e1, input logic [31:0] e2,
                        input logic [31:0] e3);
    chk({nm, ".rdata1a"}, rdata1a, e0);
    chk({nm, ".rdata1b"}, rdata1b, e1);
    chk({nm, ".rdata2a"}, rdata2a, e2);
    chk({nm, ".rdata2b"}, rdata2b, e3);
  endtask

  task automatic no_wr();
    we1 = 1'b0; we2 = 1'b0;
  endtask

  initial begin
    vecs[0] = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,
                 5, 5, 0, 1,
                 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    vecs[1] = mk(0, 0, 0, 1, 0, 32'hFFFFFFFF,
                 0, 0, 0, 5,
                 0, 0, 0, 32'hDEADBEEF, 0);
    vecs[2] = mk(1, 3, 32'h11, 1, 4, 32'h22,
                 3, 4, 5, 0,
                 32'h11, 32'h22, 32'hDEADBEEF, 0, 0);
    vecs[3] = mk(1, 0, 32'h1234, 1, 0, 32'h5678,
                 0, 3, 4, 0,
                 0, 32'h11, 32'h22, 0, 0);
    vecs[4] = mk(1, 31, 32'hCAFEF00D, 1, 1, 32'h1,
                 31, 1, 30, 0,
                 32'hCAFEF00D, 32'h1, 0, 0, 0);
    vecs[5] = mk(1, 3, 32'h33, 0, 3, 32'h99,
                 3, 4, 31, 1,
                 32'h33, 32'h22, 32'hCAFEF00D, 32'h1, 0);
    vecs[6] = mk(1, 7, 32'hAA, 1, 7, 32'hBB,
                 7, 7, 3, 0,
                 32'hBB, 32'hBB, 32'h33, 0, 1);
    vecs[7] = mk(0, 7, 32'h1, 0, 7, 32'h2,
                 7, 5, 4, 31,
                 32'hBB, 32'hDEADBEEF, 32'h22, 32'hCAFEF00D, 1);
    vecs[8] = mk(1, 7, 32'h77, 0, 0, 0,
                 7, 3, 0, 5,
                 32'h77, 32'h33, 0, 32'hDEADBEEF, 1);

    // Reset held across an edge, with a write presented.
    we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h55;
    set_ra(2, 2, 0, 1);
    #1;
    chk_rd("in_rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    no_wr();
    rst = 1'b0;
    #1;
    chk("rst.wconflict", {31'b0, wconflict}, 0);
    for (int i = 0; i < 32; i++) begin
      set_ra(i[4:0], i[4:0], i[4:0], i[4:0]);
      #1;
      chk_rd($sformatf("rst.addr%0d", i), 0, 0, 0, 0);
    end

    // Table of write-then-read vectors.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      we1 = vecs[i].we1; waddr1 = vecs[i].wa1; wdata1 = vecs[i].wd1;
      we2 = vecs[i].we2; waddr2 = vecs[i].wa2; wdata2 = vecs[i].wd2;
      set_ra(vecs[i].ra[0], vecs[i].ra[1], vecs[i].ra[2], vecs[i].ra[3]);
      @(posedge clk);
      #1;
      no_wr();
      #1;
      chk_rd($sformatf("vec%0d", i),
             vecs[i].ex[0], vecs[i].ex[1], vecs[i].ex[2], vecs[i].ex[3]);
      chk($sformatf("vec%0d.wconflict", i), {31'b0, wconflict},
          {31'b0, vecs[i].wc});
    end

    // Same-cycle read of a register being written.
    @(negedge clk);
    we1 = 1'b1; waddr1 = 5'd10; wdata1 = 32'h12345678;
    set_ra(10, 0, 7, 10);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("raw.same_cycle", rdata1a, 32'h12345678);
`else
    chk("raw.same_cycle", rdata1a, 32'h0);
`endif
    chk("raw.other", rdata2a, 32'h77);
    @(posedge clk);
    #1;
    no_wr();
    #1;
    chk("raw.next_cycle", rdata2b, 32'h12345678);

`ifdef REGFILE_BYPASS_EN
    @(negedge clk);
    we1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'h1111;
    we2 = 1'b1; waddr2 = 5'd11; wdata2 = 32'h2222;
    set_ra(11, 0, 0, 0);
    #1;
    chk("byp.lane2_wins", rdata1a, 32'h2222);
    @(posedge clk);
    #1;
    no_wr();
`endif

    // Async reset between edges, then a write during reset.
    @(negedge clk);
    set_ra(7, 3, 10, 5);
    #1;
    chk("pre_arst.r10", rdata2a, 32'h12345678);
    rst = 1'b1;
    #1;
    chk_rd("arst", 0, 0, 0, 0);
    chk("arst.wconflict", {31'b0, wconflict}, 0);
    we2 = 1'b1; waddr2 = 5'd9; wdata2 = 32'h9999;
    set_ra(9, 7, 0, 0);
    @(posedge clk);
    #1;
    no_wr();
    rst = 1'b0;
    #1;
    chk_rd("post_arst", 0, 0, 0, 0);
    chk("post_arst.wconflict", {31'b0, wconflict}, 0);

    // Register file writable again after reset.
    @(negedge clk);
    we2 = 1'b1; waddr2 = 5'd9; wdata2 = 32'hABCD0123;
    @(posedge clk);
    #1;
    no_wr();
    #1;
    chk("after_rst.w9", rdata1a, 32'hABCD0123);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
